regf_scoreboard: RTL

//   Parametrised integer register file for the RISC-V core: 2 read ports, 1 write port, hardwired-zero x0.

---
 rtl/regf_scoreboard_if.sv | 31 +++
 rtl/regf_scoreboard.sv | 80 ++++++++
 2 files changed

// File: rtl/regf_scoreboard_if.sv
// rtl/regf_scoreboard_if.sv - decode/writeback bus of the register file with busy scoreboard
interface regf_scoreboard_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic              rw;
  logic              wr;
  logic [ADDR_W-1:0] Ad_rs1;
  logic [ADDR_W-1:0] Ad_rs2;
  logic [ADDR_W-1:0] Ad_rd;
  logic [XLEN-1:0]   rd_data_in;
  logic              issue;
  logic [ADDR_W-1:0] issue_rd;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              hazard;

  modport master (
    output rw, wr, Ad_rs1, Ad_rs2, Ad_rd, rd_data_in, issue, issue_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, hazard
  );

  modport slave (
    input  rw, wr, Ad_rs1, Ad_rs2, Ad_rd, rd_data_in, issue, issue_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, hazard
  );
endinterface

// File: rtl/regf_scoreboard.sv
// rtl/regf_scoreboard.sv - 2R/1W integer register file, hardwired x0, per-register busy scoreboard
module regf_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1
) (
  input logic              clk,
  input logic              rst,
  regf_scoreboard_if.slave bus
);
  localparam logic BYP = (BYPASS != 0);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]     rs1_q, rs1_d;
  logic [XLEN-1:0]     rs2_q, rs2_d;
  logic                wr_ok, fwd1, fwd2, iss_ok;

  assign wr_ok  = bus.wr && (bus.Ad_rd != '0);
  assign iss_ok = bus.issue && (bus.issue_rd != '0);
  // A writeback to the register being read this cycle both forwards its data and clears its hazard.
  assign fwd1   = BYP && wr_ok && (bus.Ad_rd == bus.Ad_rs1);
  assign fwd2   = BYP && wr_ok && (bus.Ad_rd == bus.Ad_rs2);

  always_comb begin
    rs1_d = rs1_q;
    if (bus.rw) begin
      if (bus.Ad_rs1 == '0)
        rs1_d = '0;
      else if (fwd1)
        rs1_d = bus.rd_data_in;
      else
        rs1_d = regs_q[bus.Ad_rs1];
    end
  end

  always_comb begin
    rs2_d = rs2_q;
    if (bus.rw) begin
      if (bus.Ad_rs2 == '0)
        rs2_d = '0;
      else if (fwd2)
        rs2_d = bus.rd_data_in;
      else
        rs2_d = regs_q[bus.Ad_rs2];
    end
  end

  // Clear first, then set, so a new producer issued on the writeback edge stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)
      busy_d[bus.Ad_rd] = 1'b0;
    if (iss_ok)
      busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
      busy_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else begin
      if (wr_ok)
        regs_q[bus.Ad_rd] <= bus.rd_data_in;
      busy_q <= busy_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
    end
  end

  assign bus.rs1_data = rs1_q;
  assign bus.rs2_data = rs2_q;
  assign bus.rs1_busy = busy_q[bus.Ad_rs1] & ~fwd1;
  assign bus.rs2_busy = busy_q[bus.Ad_rs2] & ~fwd2;
  assign bus.hazard   = bus.rw & (bus.rs1_busy | bus.rs2_busy);
endmodule
